sha256_round_sequencer: RTL

- Iterative SHA-256 compression controller: accepts one 512-bit message block plus a 256-bit chaining value, sequences 64 rounds through a single shared round datapath, and returns the updated chaining value.
- The datapath comprises the Sigma0/Sigma1, Ch and Maj functions and the message-schedule sigma0/sigma1.
- Sits between the mining/hash top level, which handles padding, IV and multi-block chaining, and the bit-function blocks.
- One round per clock; start/busy/done handshake.

---
 rtl/sha256_pkg.sv | 47 ++++
 rtl/sha256_k_rom.sv | 49 ++++
 rtl/sha256_round_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: IV words, controller state encoding, word width
// and the bit-level round/schedule functions.
package sha256_pkg;

   localparam int WORD_W = 32;

   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2
   } sha_state_e;

   function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x,
                                            input logic [WORD_W-1:0] y,
                                            input logic [WORD_W-1:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x,
                                             input logic [WORD_W-1:0] y,
                                             input logic [WORD_W-1:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   // Rotations are fixed, so they are written as plain rewiring.
   function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
   endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Round-constant table: maps a 6-bit round index to the FIPS 180-4 K[t] word.
module sha256_k_rom
   import sha256_pkg::*;
(
   input  logic [5:0]        idx_i,
   output logic [WORD_W-1:0] k_o
);

   // Pure lookup, no state.
   always_comb begin
      k_o = 32'h00000000;
      case (idx_i)
         6'd0:  k_o = 32'h428a2f98;  6'd1:  k_o = 32'h71374491;
         6'd2:  k_o = 32'hb5c0fbcf;  6'd3:  k_o = 32'he9b5dba5;
         6'd4:  k_o = 32'h3956c25b;  6'd5:  k_o = 32'h59f111f1;
         6'd6:  k_o = 32'h923f82a4;  6'd7:  k_o = 32'hab1c5ed5;
         6'd8:  k_o = 32'hd807aa98;  6'd9:  k_o = 32'h12835b01;
         6'd10: k_o = 32'h243185be;  6'd11: k_o = 32'h550c7dc3;
         6'd12: k_o = 32'h72be5d74;  6'd13: k_o = 32'h80deb1fe;
         6'd14: k_o = 32'h9bdc06a7;  6'd15: k_o = 32'hc19bf174;
         6'd16: k_o = 32'he49b69c1;  6'd17: k_o = 32'hefbe4786;
         6'd18: k_o = 32'h0fc19dc6;  6'd19: k_o = 32'h240ca1cc;
         6'd20: k_o = 32'h2de92c6f;  6'd21: k_o = 32'h4a7484aa;
         6'd22: k_o = 32'h5cb0a9dc;  6'd23: k_o = 32'h76f988da;
         6'd24: k_o = 32'h983e5152;  6'd25: k_o = 32'ha831c66d;
         6'd26: k_o = 32'hb00327c8;  6'd27: k_o = 32'hbf597fc7;
         6'd28: k_o = 32'hc6e00bf3;  6'd29: k_o = 32'hd5a79147;
         6'd30: k_o = 32'h06ca6351;  6'd31: k_o = 32'h14292967;
         6'd32: k_o = 32'h27b70a85;  6'd33: k_o = 32'h2e1b2138;
         6'd34: k_o = 32'h4d2c6dfc;  6'd35: k_o = 32'h53380d13;
         6'd36: k_o = 32'h650a7354;  6'd37: k_o = 32'h766a0abb;
         6'd38: k_o = 32'h81c2c92e;  6'd39: k_o = 32'h92722c85;
         6'd40: k_o = 32'ha2bfe8a1;  6'd41: k_o = 32'ha81a664b;
         6'd42: k_o = 32'hc24b8b70;  6'd43: k_o = 32'hc76c51a3;
         6'd44: k_o = 32'hd192e819;  6'd45: k_o = 32'hd6990624;
         6'd46: k_o = 32'hf40e3585;  6'd47: k_o = 32'h106aa070;
         6'd48: k_o = 32'h19a4c116;  6'd49: k_o = 32'h1e376c08;
         6'd50: k_o = 32'h2748774c;  6'd51: k_o = 32'h34b0bcb5;
         6'd52: k_o = 32'h391c0cb3;  6'd53: k_o = 32'h4ed8aa4a;
         6'd54: k_o = 32'h5b9cca4f;  6'd55: k_o = 32'h682e6ff3;
         6'd56: k_o = 32'h748f82ee;  6'd57: k_o = 32'h78a5636f;
         6'd58: k_o = 32'h84c87814;  6'd59: k_o = 32'h8cc70208;
         6'd60: k_o = 32'h90befffa;  6'd61: k_o = 32'ha4506ceb;
         6'd62: k_o = 32'hbef9a3f7;  6'd63: k_o = 32'hc67178f2;
         default: k_o = 32'h00000000;
      endcase
   end

endmodule

// File: rtl/sha256_round_sequencer.sv
// Iterative SHA-256 compression: one round per clock over a shared datapath,
// start/busy/done handshake, chaining value added back in the FINAL cycle.
module sha256_round_sequencer
   import sha256_pkg::*;
#(
   parameter int ROUNDS = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [511:0] block_in,
   input  logic [255:0] hash_in,
   output logic         busy,
   output logic         done,
   output logic [255:0] hash_out
);

   localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

   sha_state_e        state_q;
   logic [5:0]        t_q;
   logic [WORD_W-1:0] h_q    [8];
   logic [WORD_W-1:0] work_q [8];
   logic [WORD_W-1:0] w_q    [16];
   logic              busy_q;
   logic              done_q;
   logic [255:0]      hash_out_q;

   logic [WORD_W-1:0] k_d;
   logic [WORD_W-1:0] t1_d;
   logic [WORD_W-1:0] t2_d;
   logic [WORD_W-1:0] w_new_d;

   sha256_k_rom u_k_rom (
      .idx_i (t_q),
      .k_o   (k_d)
   );

   // work_q[0..7] hold a..h.
   assign t1_d = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
               + k_d + w_q[0];
   assign t2_d = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
   assign w_new_d = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

   // Controller FSM together with the working, schedule and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         t_q        <= 6'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hash_out_q <= 256'd0;
         for (int i = 0; i < 8; i++) begin
            h_q[i]    <= 32'd0;
            work_q[i] <= 32'd0;
         end
         for (int i = 0; i < 16; i++) begin
            w_q[i] <= 32'd0;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  for (int i = 0; i < 8; i++) begin
                     h_q[i]    <= hash_in[255-32*i -: 32];
                     work_q[i] <= hash_in[255-32*i -: 32];
                  end
                  for (int i = 0; i < 16; i++) begin
                     w_q[i] <= block_in[511-32*i -: 32];
                  end
                  t_q     <= 6'd0;
                  busy_q  <= 1'b1;
                  state_q <= ST_ROUND;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ROUND: begin
               work_q[0] <= t1_d + t2_d;
               work_q[1] <= work_q[0];
               work_q[2] <= work_q[1];
               work_q[3] <= work_q[2];
               work_q[4] <= work_q[3] + t1_d;
               work_q[5] <= work_q[4];
               work_q[6] <= work_q[5];
               work_q[7] <= work_q[6];
               for (int i = 0; i < 15; i++) begin
                  w_q[i] <= w_q[i+1];
               end
               w_q[15] <= w_new_d;
               t_q     <= t_q + 6'd1;
               if (t_q == LAST_T) begin
                  state_q <= ST_FINAL;
               end else begin
                  state_q <= ST_ROUND;
               end
            end
            ST_FINAL: begin
               for (int i = 0; i < 8; i++) begin
                  hash_out_q[255-32*i -: 32] <= h_q[i] + work_q[i];
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hash_out = hash_out_q;

endmodule
